// File: rtl/cache_axi_pkg.sv
// Shared constants, transfer-type codes and FSM state types for the
// cache-to-AXI arbiter.
package cache_axi_pkg;

   localparam logic [2:0] TYPE_WORD      = 3'b010;
   localparam logic [2:0] TYPE_LINE      = 3'b100;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [3:0] ID_ICACHE      = 4'd0;
   localparam logic [3:0] ID_DCACHE      = 4'd1;

   typedef enum logic [1:0] {
      R_IDLE,
      R_AR,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_AW,
      W_DATA,
      W_RESP
   } wr_state_t;

   // A line access is a 4-beat burst; everything else is one word.
   function automatic logic [7:0] burst_len(input logic [2:0] req_type);
      return (req_type == TYPE_LINE) ? 8'd3 : 8'd0;
   endfunction

endpackage

// File: rtl/axi_wr_channel.sv
// Dcache write-back path: latches one write request and plays it out on the
// AXI AW, W and B channels, one transaction at a time.
module axi_wr_channel
   import cache_axi_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  addr,
   input  logic [3:0]   strb,
   input  logic [127:0] data,
   output logic         rdy,
   output logic         busy,
   output logic [27:0]  line,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic         bvalid,
   output logic         bready
);

   wr_state_t    state;
   wr_state_t    state_next;
   logic [1:0]   beat;
   logic [127:0] data_q;
   logic         last_beat;

   assign last_beat = (beat == awlen[1:0]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= W_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         W_IDLE:  if (req)                   state_next = W_AW;
         W_AW:    if (awready)               state_next = W_DATA;
         W_DATA:  if (wready && last_beat)   state_next = W_RESP;
         W_RESP:  if (bvalid)                state_next = W_IDLE;
         default:                            state_next = W_IDLE;
      endcase
   end

   // Request fields are captured on acceptance and held until the next one,
   // so every AXI field stays stable while its valid is high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awid   <= 4'd0;
         awaddr <= 32'd0;
         awlen  <= 8'd0;
         wstrb  <= 4'd0;
         data_q <= 128'd0;
         beat   <= 2'd0;
      end else if (state == W_IDLE && req) begin
         awid   <= ID_DCACHE;
         awaddr <= addr;
         awlen  <= burst_len(wr_type);
         wstrb  <= (wr_type == TYPE_LINE) ? 4'hf : strb;
         data_q <= data;
         beat   <= 2'd0;
      end else if (state == W_DATA && wready) begin
         beat   <= beat + 2'd1;
      end
   end

   assign rdy     = resetn && (state == W_IDLE);
   assign busy    = (state != W_IDLE);
   assign line    = awaddr[31:4];
   assign awsize  = AXI_SIZE_4B;
   assign awburst = AXI_BURST_INCR;
   assign awvalid = (state == W_AW);
   assign wvalid  = (state == W_DATA);
   assign wlast   = (state == W_DATA) && last_beat;
   assign wdata   = data_q[{beat, 5'b00000} +: 32];
   assign bready  = (state == W_RESP);

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master between icache reads and dcache reads/write-backs,
// with one read and one write outstanding and read-after-write line blocking.
module cache_axi_arbiter
   import cache_axi_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         ic_rd_req,
   input  logic [2:0]   ic_rd_type,
   input  logic [31:0]  ic_rd_addr,
   output logic         ic_rd_rdy,
   output logic         ic_ret_valid,
   output logic         ic_ret_last,
   input  logic         dc_rd_req,
   input  logic [2:0]   dc_rd_type,
   input  logic [31:0]  dc_rd_addr,
   output logic         dc_rd_rdy,
   output logic         dc_ret_valid,
   output logic         dc_ret_last,
   output logic [31:0]  ret_data,
   input  logic         dc_wr_req,
   input  logic [2:0]   dc_wr_type,
   input  logic [31:0]  dc_wr_addr,
   input  logic [3:0]   dc_wr_wstrb,
   input  logic [127:0] dc_wr_data,
   output logic         dc_wr_rdy,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [3:0]   rid,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic [3:0]   bid,
   input  logic [1:0]   bresp,
   input  logic         bvalid,
   output logic         bready
);

   rd_state_t   rstate;
   rd_state_t   rstate_next;
   logic        owner_dc;
   logic        wr_busy;
   logic [27:0] wr_line;
   logic        wr_accept;
   logic        dc_hazard;
   logic        ic_hazard;
   logic        rd_idle;
   logic        unused_inputs;

   assign unused_inputs = ^{rid, rresp, bid, bresp};

   axi_wr_channel u_wr (
      .clk     (clk),
      .resetn  (resetn),
      .req     (dc_wr_req),
      .wr_type (dc_wr_type),
      .addr    (dc_wr_addr),
      .strb    (dc_wr_wstrb),
      .data    (dc_wr_data),
      .rdy     (dc_wr_rdy),
      .busy    (wr_busy),
      .line    (wr_line),
      .awid    (awid),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .wvalid  (wvalid),
      .wready  (wready),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   // A read must not overtake a write to the same line, whether that write is
   // already in flight or being accepted this very cycle.
   assign wr_accept = dc_wr_req && dc_wr_rdy;
   assign dc_hazard = (wr_busy && dc_rd_addr[31:4] == wr_line) ||
                      (wr_accept && dc_rd_addr[31:4] == dc_wr_addr[31:4]);
   assign ic_hazard = (wr_busy && ic_rd_addr[31:4] == wr_line) ||
                      (wr_accept && ic_rd_addr[31:4] == dc_wr_addr[31:4]);

   // A blocked dcache request keeps the grant, so icache cannot slip past it.
   assign rd_idle   = resetn && (rstate == R_IDLE);
   assign dc_rd_rdy = rd_idle && dc_rd_req && !dc_hazard;
   assign ic_rd_rdy = rd_idle && !dc_rd_req && ic_rd_req && !ic_hazard;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rstate <= R_IDLE;
      else         rstate <= rstate_next;
   end

   always_comb begin
      rstate_next = rstate;
      case (rstate)
         R_IDLE:  if (dc_rd_rdy || ic_rd_rdy) rstate_next = R_AR;
         R_AR:    if (arready)                rstate_next = R_DATA;
         R_DATA:  if (rvalid && rlast)        rstate_next = R_IDLE;
         default:                             rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_dc <= 1'b0;
         arid     <= 4'd0;
         araddr   <= 32'd0;
         arlen    <= 8'd0;
      end else if (dc_rd_rdy) begin
         owner_dc <= 1'b1;
         arid     <= ID_DCACHE;
         araddr   <= dc_rd_addr;
         arlen    <= burst_len(dc_rd_type);
      end else if (ic_rd_rdy) begin
         owner_dc <= 1'b0;
         arid     <= ID_ICACHE;
         araddr   <= ic_rd_addr;
         arlen    <= burst_len(ic_rd_type);
      end
   end

   assign arsize       = AXI_SIZE_4B;
   assign arburst      = AXI_BURST_INCR;
   assign arvalid      = (rstate == R_AR);
   assign rready       = (rstate == R_DATA);
   assign ret_data     = rdata;
   assign dc_ret_valid = rready && owner_dc && rvalid;
   assign dc_ret_last  = rready && owner_dc && rlast;
   assign ic_ret_valid = rready && !owner_dc && rvalid;
   assign ic_ret_last  = rready && !owner_dc && rlast;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: the bench plays the AXI slave by hand
// and checks every handshake against hand-computed values.
module tb_cache_axi_arbiter;
   import cache_axi_pkg::*;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ic_rd_req, dc_rd_req, dc_wr_req;
   logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
   logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
   logic [3:0]   dc_wr_wstrb;
   logic [127:0] dc_wr_data;
   logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
   logic         dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_wr_rdy;
   logic [31:0]  ret_data;
   logic [3:0]   arid, awid, rid, bid;
   logic [31:0]  araddr, awaddr, rdata, wdata;
   logic [7:0]   arlen, awlen;
   logic [2:0]   arsize, awsize;
   logic [1:0]   arburst, awburst, rresp, bresp;
   logic         arvalid, arready, rlast, rvalid, rready;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]   wstrb;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] LINE_DATA = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
   localparam logic [127:0] WORD_DATA = {96'd0, 32'hCAFE_BABE};
   localparam logic [127:0] HAZ_DATA  = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};

   always #5 clk = ~clk;

   cache_axi_arbiter dut (
      .clk(clk), .resetn(resetn),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
      .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
      .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
      .ret_data(ret_data),
      .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
      .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, away from sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Serve an R burst; entered with the read FSM in R_DATA.
   task automatic serve_r(input int beats, input logic [31:0] base, input logic to_dc);
      for (int i = 0; i < beats; i++) begin
         rvalid = 1'b1;
         rdata  = base + i;
         rlast  = (i == beats - 1);
         #1;
         check_output("ret_data", ret_data, base + i);
         check_output("owner_ret_valid", to_dc ? dc_ret_valid : ic_ret_valid, 1'b1);
         check_output("other_ret_valid", to_dc ? ic_ret_valid : dc_ret_valid, 1'b0);
         check_output("owner_ret_last", to_dc ? dc_ret_last : ic_ret_last, (i == beats - 1));
         step();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      #1;
      check_output("rready_after_last", rready, 1'b0);
   endtask

   // Accept W beats then B; entered with the write FSM in W_DATA.
   task automatic write_beats(input int beats, input logic [127:0] data, input logic [3:0] strb);
      wready = 1'b1;
      for (int i = 0; i < beats; i++) begin
         #1;
         check_output("wvalid", wvalid, 1'b1);
         check_output("wdata", wdata, data[32*i +: 32]);
         check_output("wlast", wlast, (i == beats - 1));
         check_output("wstrb", wstrb, strb);
         step();
      end
      wready = 1'b0;
      #1;
      check_output("bready", bready, 1'b1);
      check_output("wvalid_in_resp", wvalid, 1'b0);
      check_output("wr_rdy_in_resp", dc_wr_rdy, 1'b0);
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      #1;
      check_output("wr_rdy_after_b", dc_wr_rdy, 1'b1);
      check_output("bready_after_b", bready, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
      dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
      dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

      repeat (3) @(posedge clk);
      #1;
      check_output("rst_arvalid", arvalid, 1'b0);
      check_output("rst_rready", rready, 1'b0);
      check_output("rst_awvalid", awvalid, 1'b0);
      check_output("rst_wvalid", wvalid, 1'b0);
      check_output("rst_bready", bready, 1'b0);
      check_output("rst_wr_rdy", dc_wr_rdy, 1'b0);
      check_output("rst_araddr", araddr, 32'd0);
      check_output("rst_arlen", arlen, 8'd0);
      check_output("rst_awaddr", awaddr, 32'd0);
      check_output("rst_awid", awid, 4'd0);
      check_output("rst_wdata", wdata, 32'd0);
      resetn = 1'b1;
      #1;
      check_output("idle_wr_rdy", dc_wr_rdy, 1'b1);

      $display("[TB] icache line read");
      step();
      ic_rd_req = 1; ic_rd_type = TYPE_LINE; ic_rd_addr = 32'h1FC0_0010;
      #1;
      check_output("ic_rd_rdy", ic_rd_rdy, 1'b1);
      check_output("dc_rd_rdy_idle", dc_rd_rdy, 1'b0);
      check_output("arvalid_same_cycle", arvalid, 1'b0);
      step();
      ic_rd_req = 0;
      #1;
      check_output("ic_arvalid", arvalid, 1'b1);
      check_output("ic_araddr", araddr, 32'h1FC0_0010);
      check_output("ic_arlen", arlen, 8'd3);
      check_output("ic_arid", arid, 4'd0);
      check_output("arsize", arsize, 3'b010);
      check_output("arburst", arburst, 2'b01);
      arready = 1;
      step();
      arready = 0;
      #1;
      check_output("arvalid_dropped", arvalid, 1'b0);
      check_output("rready", rready, 1'b1);
      serve_r(4, 32'hA0, 1'b0);

      $display("[TB] simultaneous read requests");
      step();
      dc_rd_req = 1; dc_rd_type = TYPE_LINE; dc_rd_addr = 32'h0000_0100;
      ic_rd_req = 1; ic_rd_type = TYPE_WORD; ic_rd_addr = 32'h0000_0200;
      #1;
      check_output("prio_dc_rdy", dc_rd_rdy, 1'b1);
      check_output("prio_ic_rdy", ic_rd_rdy, 1'b0);
      step();
      dc_rd_req = 0;
      #1;
      check_output("dc_arid", arid, 4'd1);
      check_output("dc_araddr", araddr, 32'h0000_0100);
      check_output("ic_wait_rdy", ic_rd_rdy, 1'b0);
      arready = 1;
      step();
      arready = 0;
      serve_r(4, 32'hB0, 1'b1);
      check_output("ic_rdy_after_rlast", ic_rd_rdy, 1'b1);
      step();
      ic_rd_req = 0;
      #1;
      check_output("ic2_arid", arid, 4'd0);
      check_output("ic2_araddr", araddr, 32'h0000_0200);
      check_output("ic2_arlen", arlen, 8'd0);
      arready = 1;
      step();
      arready = 0;
      serve_r(1, 32'hC0, 1'b0);

      $display("[TB] dcache line write");
      step();
      dc_wr_req = 1; dc_wr_type = TYPE_LINE; dc_wr_addr = 32'h0000_1230;
      dc_wr_wstrb = 4'h0; dc_wr_data = LINE_DATA;
      #1;
      check_output("wr_rdy", dc_wr_rdy, 1'b1);
      step();
      dc_wr_req = 0;
      #1;
      check_output("awvalid", awvalid, 1'b1);
      check_output("awaddr", awaddr, 32'h0000_1230);
      check_output("awlen_line", awlen, 8'd3);
      check_output("awid", awid, 4'd1);
      check_output("wvalid_in_aw", wvalid, 1'b0);
      awready = 1;
      step();
      awready = 0;
      write_beats(4, LINE_DATA, 4'hf);

      $display("[TB] uncached word write");
      step();
      dc_wr_req = 1; dc_wr_type = TYPE_WORD; dc_wr_addr = 32'h0000_2004;
      dc_wr_wstrb = 4'b0110; dc_wr_data = WORD_DATA;
      #1;
      check_output("word_wr_rdy", dc_wr_rdy, 1'b1);
      step();
      dc_wr_req = 0;
      #1;
      check_output("word_awlen", awlen, 8'd0);
      check_output("word_awaddr", awaddr, 32'h0000_2004);
      awready = 1;
      step();
      awready = 0;
      write_beats(1, WORD_DATA, 4'b0110);

      $display("[TB] read-after-write hazard with stalled awready");
      step();
      dc_wr_req = 1; dc_wr_type = TYPE_LINE; dc_wr_addr = 32'h0000_1230; dc_wr_data = HAZ_DATA;
      dc_rd_req = 1; dc_rd_type = TYPE_WORD; dc_rd_addr = 32'h0000_1238;
      #1;
      check_output("haz_wr_rdy", dc_wr_rdy, 1'b1);
      check_output("haz_same_cycle", dc_rd_rdy, 1'b0);
      step();
      dc_wr_req = 0;
      ic_rd_req = 1; ic_rd_type = TYPE_LINE; ic_rd_addr = 32'h0000_2000;
      #1;
      check_output("haz_inflight", dc_rd_rdy, 1'b0);
      check_output("haz_grant_held", ic_rd_rdy, 1'b0);
      check_output("haz_awvalid", awvalid, 1'b1);
      step();
      dc_rd_req = 0;
      #1;
      check_output("haz_ic_proceeds", ic_rd_rdy, 1'b1);
      step();
      ic_rd_req = 0;
      #1;
      check_output("haz_ic_arvalid", arvalid, 1'b1);
      check_output("haz_ic_araddr", araddr, 32'h0000_2000);
      arready = 1;
      step();
      arready = 0;
      for (int i = 0; i < 4; i++) begin
         rvalid = 1; rdata = 32'h5000_0000 + i; rlast = (i == 3);
         #1;
         check_output("stall_ret_valid", ic_ret_valid, 1'b1);
         check_output("stall_ret_data", ret_data, 32'h5000_0000 + i);
         check_output("stall_awvalid", awvalid, 1'b1);
         check_output("stall_awaddr", awaddr, 32'h0000_1230);
         step();
      end
      rvalid = 0; rlast = 0;
      dc_rd_req = 1; dc_rd_addr = 32'h0000_1238;
      #1;
      check_output("haz_still_blocked", dc_rd_rdy, 1'b0);
      awready = 1;
      step();
      awready = 0;
      write_beats(4, HAZ_DATA, 4'hf);
      check_output("haz_released", dc_rd_rdy, 1'b1);
      step();
      dc_rd_req = 0;
      #1;
      check_output("haz_dc_arid", arid, 4'd1);
      check_output("haz_dc_araddr", araddr, 32'h0000_1238);
      arready = 1;
      step();
      arready = 0;
      rvalid = 1; rdata = 32'hE0;
      #1;
      check_output("pre_rst_ret_valid", dc_ret_valid, 1'b1);
      check_output("pre_rst_rready", rready, 1'b1);
      resetn = 0;
      #1;
      check_output("mid_rst_rready", rready, 1'b0);
      check_output("mid_rst_arvalid", arvalid, 1'b0);
      check_output("mid_rst_ret_valid", dc_ret_valid, 1'b0);
      check_output("mid_rst_araddr", araddr, 32'd0);
      rvalid = 0;
      step();
      resetn = 1;
      #1;
      check_output("post_rst_rready", rready, 1'b0);
      check_output("post_rst_wr_rdy", dc_wr_rdy, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
